// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared FSM state type and LFSR mode selectors
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MODE_FIBONACCI = 0;
  localparam int MODE_GALOIS    = 1;

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - LFSR register with seed load, zero-seed substitution and one-step update
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter int               MODE         = MODE_GALOIS,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] stepped;

  // An all-zero register is a lock-up state, so a zero seed is replaced
  generate
    if (MODE == MODE_GALOIS) begin : g_galois
      assign stepped = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end else begin : g_fibonacci
      assign stepped = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  endgenerate

  // Register update: load has priority over step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEED_DEFAULT;
    end else if (load) begin
      state_q <= (load_data == '0) ? SEED_DEFAULT : load_data;
    end else if (step) begin
      state_q <= stepped;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_engine.sv
// rtl/lfsr_engine.sv - request/response LFSR engine advancing N steps per request
module lfsr_engine
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter int               MODE         = MODE_GALOIS,
  parameter int               CNT_W        = 8,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_val,
  input  logic [WIDTH-1:0] seed,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [CNT_W-1:0] req_nshift,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load;
  logic             step;

  lfsr_core #(
    .WIDTH       (WIDTH),
    .TAPS        (TAPS),
    .MODE        (MODE),
    .SEED_DEFAULT(SEED_DEFAULT)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(seed),
    .step     (step),
    .state    (resp_data)
  );

  // State and remaining-step counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, handshakes and LFSR controls; a seed load blocks request acceptance
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_rdy  = 1'b0;
    resp_val = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: begin
        req_rdy = !seed_val;
        load    = seed_val;
        if (req_val && !seed_val) begin
          if (req_nshift != '0) begin
            cnt_d   = req_nshift;
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        step  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        resp_val = 1'b1;
        if (resp_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_engine.sv
// tb/tb_lfsr_engine.sv - directed self-checking bench for lfsr_engine
module tb_lfsr_engine;
  import lfsr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_val;
  logic        req_val;
  logic [7:0]  req_nshift;
  logic        resp_rdy;
  logic [15:0] seed_g, seed_f;
  logic [3:0]  seed_4;

  logic        req_rdy_g, resp_val_g, busy_g;
  logic        req_rdy_4, resp_val_4, busy_4;
  logic        req_rdy_f, resp_val_f, busy_f;
  logic [15:0] data_g, data_f;
  logic [3:0]  data_4;

  int total = 0;
  int bad   = 0;
  int lat;
  int seen;

  always #5 clk = ~clk;

  lfsr_engine u_g (
    .clk(clk), .rst(rst), .seed_val(seed_val), .seed(seed_g),
    .req_val(req_val), .req_rdy(req_rdy_g), .req_nshift(req_nshift),
    .resp_val(resp_val_g), .resp_rdy(resp_rdy), .resp_data(data_g), .busy(busy_g)
  );

  lfsr_engine #(.WIDTH(4), .TAPS(4'hC), .MODE(MODE_GALOIS), .SEED_DEFAULT(4'h1)) u_4 (
    .clk(clk), .rst(rst), .seed_val(seed_val), .seed(seed_4),
    .req_val(req_val), .req_rdy(req_rdy_4), .req_nshift(req_nshift),
    .resp_val(resp_val_4), .resp_rdy(resp_rdy), .resp_data(data_4), .busy(busy_4)
  );

  lfsr_engine #(.MODE(MODE_FIBONACCI)) u_f (
    .clk(clk), .rst(rst), .seed_val(seed_val), .seed(seed_f),
    .req_val(req_val), .req_rdy(req_rdy_f), .req_nshift(req_nshift),
    .resp_val(resp_val_f), .resp_rdy(resp_rdy), .resp_data(data_f), .busy(busy_f)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; lat = edges from the accepting edge until resp_val is seen
  task automatic do_req(input logic [7:0] n, output int l);
    req_nshift = n;
    req_val    = 1'b1;
    tick();
    req_val    = 1'b0;
    req_nshift = 8'hFF;
    l = 1;
    while (resp_val_g !== 1'b1 && l < 300) begin
      tick();
      l++;
    end
    if (l >= 300) chk("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic consume();
    resp_rdy = 1'b1;
    #1;
    chk("consume_val", resp_val_g, 1'b1);
    chk("consume_no_bypass", req_rdy_g, 1'b0);
    tick();
    resp_rdy = 1'b0;
    chk("consume_idle_busy", busy_g, 1'b0);
    chk("consume_idle_rdy", req_rdy_g, 1'b1);
  endtask

  task automatic load_seed(input logic [15:0] sg, input logic [3:0] s4, input logic [15:0] sf);
    seed_g     = sg;
    seed_4     = s4;
    seed_f     = sf;
    seed_val   = 1'b1;
    req_val    = 1'b1;
    req_nshift = 8'd3;
    #1;
    chk("seed_blocks_rdy", req_rdy_g, 1'b0);
    tick();
    seed_val = 1'b0;
    req_val  = 1'b0;
    chk("seed_no_accept", busy_g, 1'b0);
  endtask

  initial begin
    rst = 1'b0; seed_val = 1'b0; req_val = 1'b0; req_nshift = '0; resp_rdy = 1'b0;
    seed_g = '0; seed_4 = '0; seed_f = '0;
    #12;
    chk("rst_data_g", data_g, 16'h0001);
    chk("rst_data_4", data_4, 4'h1);
    chk("rst_data_f", data_f, 16'h0001);
    chk("rst_busy", busy_g, 1'b0);
    chk("rst_resp_val", resp_val_g, 1'b0);
    chk("rst_req_rdy", req_rdy_g, 1'b1);

    // Release between edges; the first rising edge must accept
    @(negedge clk);
    rst = 1'b1;
    do_req(8'd0, lat);
    chk("n0_latency", lat, 1);
    chk("n0_data", data_g, 16'h0001);
    chk("n0_busy", busy_g, 1'b1);
    consume();

    load_seed(16'hACE1, 4'h1, 16'h0001);
    chk("seed_g", data_g, 16'hACE1);

    do_req(8'd1, lat);
    chk("n1_latency", lat, 2);
    chk("g_step1", data_g, 16'hE270);
    chk("w4_step1", data_4, 4'hC);
    chk("f_step1", data_f, 16'h0002);
    consume();
    do_req(8'd1, lat);
    chk("g_step2", data_g, 16'h7138);
    chk("w4_step2", data_4, 4'h6);
    chk("f_step2", data_f, 16'h0004);
    consume();
    do_req(8'd1, lat);
    chk("g_step3", data_g, 16'h389C);
    chk("w4_step3", data_4, 4'h3);
    chk("f_step3", data_f, 16'h0008);
    consume();
    do_req(8'd1, lat);
    chk("g_step4", data_g, 16'h1C4E);
    chk("w4_step4", data_4, 4'hD);
    chk("f_step4", data_f, 16'h0010);
    consume();

    // Zero seed on the Fibonacci instance is replaced by the default
    load_seed(16'hACE1, 4'h1, 16'h0000);
    chk("f_zero_seed", data_f, 16'h0001);

    do_req(8'd15, lat);
    chk("n15_latency", lat, 16);
    chk("w4_period", data_4, 4'h1);

    // Stall in DONE while pushing seeds and requests that must be ignored
    for (int i = 0; i < 5; i++) begin
      seed_val   = 1'b1;
      seed_4     = 4'h7;
      req_val    = 1'b1;
      req_nshift = 8'd2;
      tick();
      chk("stall_val", resp_val_g, 1'b1);
      chk("stall_data", data_4, 4'h1);
      chk("stall_rdy", req_rdy_g, 1'b0);
    end
    seed_val = 1'b0;
    req_val  = 1'b0;
    consume();
    chk("stall_after", data_4, 4'h1);

    // Abort a long request part-way through
    load_seed(16'hACE1, 4'h1, 16'h0001);
    req_nshift = 8'd200;
    req_val    = 1'b1;
    tick();
    req_val = 1'b0;
    repeat (49) tick();
    chk("mid_busy", busy_g, 1'b1);
    chk("mid_no_resp", resp_val_g, 1'b0);
    rst = 1'b0;
    #1;
    chk("abort_data_g", data_g, 16'h0001);
    chk("abort_data_4", data_4, 4'h1);
    chk("abort_busy", busy_g, 1'b0);
    chk("abort_rdy", req_rdy_g, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_val_g === 1'b1) seen++;
    end
    chk("abort_no_resp", seen, 0);

    // Sequence restarts from the reset value
    do_req(8'd1, lat);
    chk("post_abort_g", data_g, 16'hB400);
    chk("post_abort_f", data_f, 16'h0002);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_engine.md
LFSR_ENGINE -- requirements
Module: lfsr_engine

Interface
REQ-001 Parameter WIDTH, default 16, LFSR register width in bits (legal 4..64).
REQ-002 Parameter TAPS, default 16'hB400, WIDTH-bit feedback tap mask.
REQ-003 Parameter MODE, default MODE_GALOIS, selects MODE_FIBONACCI or MODE_GALOIS update rule.
REQ-004 Parameter CNT_W, default 8, width of the per-request shift count.
REQ-005 Parameter SEED_DEFAULT, default 1, nonzero reset and zero-seed substitute value.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, asynchronous assert, active-low.
REQ-008 seed_val  input  1  load request for seed, honoured only in IDLE.
REQ-009 seed  input  WIDTH  seed value.
REQ-010 req_val  input  1  request to advance the LFSR req_nshift steps.
REQ-011 req_rdy  output  1  request accepted when req_val && req_rdy.
REQ-012 req_nshift  input  CNT_W  number of LFSR steps for this request.
REQ-013 resp_val  output  1  resp_data holds the result.
REQ-014 resp_rdy  input  1  consumer accepts result when resp_val && resp_rdy.
REQ-015 resp_data  output  WIDTH  current LFSR register contents.
REQ-016 busy  output  1  high in SHIFT or DONE.

Function
REQ-017 FSM states IDLE, SHIFT, DONE; only those three are reachable.
REQ-018 IDLE: req_rdy = !seed_val; resp_val = 0.
REQ-019 IDLE with seed_val: LFSR loads seed next edge, or SEED_DEFAULT if seed == 0; no request accepted that cycle.
REQ-020 IDLE, request accepted, req_nshift != 0: latch req_nshift into counter; go to SHIFT.
REQ-021 IDLE, request accepted, req_nshift == 0: go directly to DONE; LFSR unchanged.
REQ-022 SHIFT: exactly one LFSR step per cycle; counter decrements; when the counter reaches 1, the final step occurs and the FSM enters DONE.
REQ-023 Latency: resp_val asserts exactly req_nshift+1 cycles after the accepting edge (1 cycle for nshift=0).
REQ-024 Galois step: next = (state >> 1) ^ (state[0] ? TAPS : 0).
REQ-025 Fibonacci step: next = {state[WIDTH-2:0], ^(state & TAPS)}.
REQ-026 DONE: resp_val = 1; resp_data and LFSR held stable until resp_rdy; on resp_val && resp_rdy, go to IDLE next edge.
REQ-027 No bypass: req_rdy = 0 in the cycle a response is consumed; the next request is accepted no earlier than the following cycle.
REQ-028 seed_val outside IDLE is ignored, with no effect on LFSR or FSM.
REQ-029 req_val outside IDLE is ignored; req_nshift is sampled only on the accepting edge.
REQ-030 LFSR state persists across requests; each request continues the sequence.
REQ-031 resp_data = LFSR register in all states, combinational from the register only.

Reset
REQ-032 On rst low: FSM = IDLE, LFSR = SEED_DEFAULT, counter = 0, resp_val = 0, busy = 0, req_rdy = 1 (seed_val low).
REQ-033 Reset during SHIFT or DONE aborts the operation; no resp_val is produced for the aborted request.
REQ-034 After rst deasserts, the first request is accepted on the first rising edge.

Structure
REQ-035 Package lfsr_pkg holds the state enum (IDLE/SHIFT/DONE) and MODE_FIBONACCI/MODE_GALOIS constants.
REQ-036 Sub-module lfsr_core holds the WIDTH-bit register, seed load, zero-seed substitution and MODE-selected step; lfsr_engine holds FSM and counter.

Verification
REQ-037 Defaults, reset, seed 0xACE1, nshift=1 -> resp_data 0xE270 after 2 cycles.
REQ-038 Defaults, reset, nshift=0 -> resp_val next cycle, resp_data 0x0001.
REQ-039 WIDTH=4, TAPS=4'hC, Galois, seed 0x1, nshift=15 -> resp_data 0x1; nshift=1 intermediate steps give C,6,3,D.
REQ-040 MODE_FIBONACCI, defaults, seed 0x0001, nshift=1 -> 0x0002; seed 0x0000 -> LFSR loads 0x0001.
REQ-041 Hold resp_rdy low 5 cycles in DONE -> resp_val and resp_data stable; req_val and seed_val during those cycles ignored.
REQ-042 rst low mid-SHIFT (nshift=200, cycle 50) -> LFSR = 0x0001, IDLE, no resp_val.
